// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencing controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    PEND  = 2'd2,
    FLUSH = 2'd3
  } fetch_ctrl_state_t;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: turns trap/branch/stall/load-use events into
// fetch PC controls and squashes wrong-path instructions after a redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        load_use,
  input  logic        mem_stall,
  output logic [31:0] next_pc,
  output logic        load_next_pc,
  output logic        bubble_from_decoder,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        trap_ack
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  fetch_ctrl_state_t state, state_n;
  logic [CW-1:0]     flush_cnt, flush_cnt_n;
  logic [31:0]       pend_pc, pend_pc_n;
  logic              pend_trap, pend_trap_n;

  logic        redirect;
  logic [31:0] target;
  logic        issue;
  logic [31:0] issue_pc;
  logic        issue_trap;

  // Trap outranks branch when both resolve in the same cycle.
  assign redirect = trap_req | br_taken;
  assign target   = trap_req ? trap_vector : br_target;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      pend_pc   <= '0;
      pend_trap <= 1'b0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      pend_pc   <= pend_pc_n;
      pend_trap <= pend_trap_n;
    end
  end

  always_comb begin
    state_n             = state;
    flush_cnt_n         = flush_cnt;
    pend_pc_n           = pend_pc;
    pend_trap_n         = pend_trap;
    next_pc             = '0;
    load_next_pc        = 1'b0;
    bubble_from_decoder = 1'b0;
    flush_if_id         = 1'b0;
    flush_id_ex         = 1'b0;
    trap_ack            = 1'b0;
    issue               = 1'b0;
    issue_pc            = '0;
    issue_trap          = 1'b0;

    case (state)
      RUN, HOLD: begin
        bubble_from_decoder = (state == HOLD);
        if (redirect) begin
          if (!mem_stall) begin
            issue      = 1'b1;
            issue_pc   = target;
            issue_trap = trap_req;
          end else begin
            pend_pc_n           = target;
            pend_trap_n         = trap_req;
            bubble_from_decoder = 1'b1;
            state_n             = PEND;
          end
        end else if (mem_stall) begin
          bubble_from_decoder = 1'b1;
          state_n             = HOLD;
        end else begin
          state_n = RUN;
          if (load_use) begin
            bubble_from_decoder = 1'b1;
            flush_id_ex         = 1'b1;
          end
        end
      end

      PEND: begin
        // A fresh trap replaces whatever was waiting; branches are dropped here.
        issue_pc   = trap_req ? trap_vector : pend_pc;
        issue_trap = trap_req | pend_trap;
        if (mem_stall) begin
          bubble_from_decoder = 1'b1;
          pend_pc_n           = issue_pc;
          pend_trap_n         = issue_trap;
        end else begin
          issue = 1'b1;
        end
      end

      FLUSH: begin
        flush_if_id = 1'b1;
        if (trap_req && !mem_stall) begin
          issue      = 1'b1;
          issue_pc   = trap_vector;
          issue_trap = 1'b1;
        end else if (trap_req) begin
          pend_pc_n           = trap_vector;
          pend_trap_n         = 1'b1;
          bubble_from_decoder = 1'b1;
          flush_cnt_n         = '0;
          state_n             = PEND;
        end else if (mem_stall) begin
          bubble_from_decoder = 1'b1;
        end else if (flush_cnt <= CNT_ONE) begin
          flush_cnt_n = '0;
          state_n     = RUN;
        end else begin
          flush_cnt_n = flush_cnt - CNT_ONE;
        end
      end

      default: state_n = RUN;
    endcase

    if (issue) begin
      load_next_pc = 1'b1;
      next_pc      = issue_pc & PC_ALIGN_MASK;
      trap_ack     = issue_trap;
      flush_id_ex  = 1'b1;
      flush_cnt_n  = CNT_LOAD;
      state_n      = FLUSH;
    end

    // Outputs stay quiet for the whole reset interval.
    if (!rst) begin
      next_pc             = '0;
      load_next_pc        = 1'b0;
      bubble_from_decoder = 1'b0;
      flush_if_id         = 1'b0;
      flush_id_ex         = 1'b0;
      trap_ack            = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a flag-based behavioural model.
module tb_fetch_ctrl;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        load_use = 1'b0;
  logic        mem_stall = 1'b0;
  logic [31:0] next_pc;
  logic        load_next_pc;
  logic        bubble_from_decoder;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        trap_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a redirect may be waiting, some wrong-path cycles may remain, or fetch is holding.
  bit          m_pend = 0;
  logic [31:0] m_addr = '0;
  bit          m_ptrap = 0;
  int          m_flush = 0;
  bit          m_hold = 0;

  fetch_ctrl #(.FLUSH_CYCLES(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .trap_req            (trap_req),
    .trap_vector         (trap_vector),
    .br_taken            (br_taken),
    .br_target           (br_target),
    .load_use            (load_use),
    .mem_stall           (mem_stall),
    .next_pc             (next_pc),
    .load_next_pc        (load_next_pc),
    .bubble_from_decoder (bubble_from_decoder),
    .flush_if_id         (flush_if_id),
    .flush_id_ex         (flush_id_ex),
    .trap_ack            (trap_ack)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic [31:0] tv,
                               input logic b, input logic [31:0] bt,
                               input logic lu, input logic st);
    @(posedge clk);
    #1;
    rst = r; trap_req = t; trap_vector = tv; br_taken = b; br_target = bt;
    load_use = lu; mem_stall = st;
  endtask

  task automatic checkOutput(input string name, input logic e_lnp, input logic e_bub,
                             input logic e_fif, input logic e_fid, input logic e_ack,
                             input logic [31:0] e_npc);
    @(negedge clk);
    cmp({name, ".load_next_pc"}, 32'(load_next_pc), 32'(e_lnp));
    cmp({name, ".bubble"}, 32'(bubble_from_decoder), 32'(e_bub));
    cmp({name, ".flush_if_id"}, 32'(flush_if_id), 32'(e_fif));
    cmp({name, ".flush_id_ex"}, 32'(flush_id_ex), 32'(e_fid));
    cmp({name, ".trap_ack"}, 32'(trap_ack), 32'(e_ack));
    if (e_lnp || !rst) cmp({name, ".next_pc"}, next_pc, e_npc);
  endtask

  always @(negedge clk) begin : model
    logic        e_lnp, e_bub, e_fif, e_fid, e_ack;
    logic [31:0] e_npc, ia;
    bit          iss, it;
    e_lnp = 0; e_bub = 0; e_fif = 0; e_fid = 0; e_ack = 0; e_npc = '0;
    iss = 0; it = 0; ia = '0;
    if (!rst) begin
      m_pend = 0; m_addr = '0; m_ptrap = 0; m_flush = 0; m_hold = 0;
    end else if (m_pend) begin
      ia = trap_req ? trap_vector : m_addr;
      it = trap_req ? 1'b1 : m_ptrap;
      if (mem_stall) begin
        e_bub = 1; m_addr = ia; m_ptrap = it;
      end else begin
        iss = 1;
      end
    end else if (m_flush > 0) begin
      e_fif = 1;
      if (trap_req && !mem_stall) begin
        iss = 1; ia = trap_vector; it = 1;
      end else if (trap_req) begin
        e_bub = 1; m_pend = 1; m_addr = trap_vector; m_ptrap = 1; m_flush = 0;
      end else if (mem_stall) begin
        e_bub = 1;
      end else begin
        m_flush = m_flush - 1;
      end
    end else begin
      e_bub = m_hold;
      if (trap_req || br_taken) begin
        ia = trap_req ? trap_vector : br_target;
        it = trap_req;
        m_hold = 0;
        if (!mem_stall) iss = 1;
        else begin
          e_bub = 1; m_pend = 1; m_addr = ia; m_ptrap = it;
        end
      end else if (mem_stall) begin
        e_bub = 1; m_hold = 1;
      end else begin
        m_hold = 0;
        if (load_use) begin e_bub = 1; e_fid = 1; end
      end
    end
    if (iss) begin
      e_lnp = 1; e_npc = ia - (ia % 4); e_ack = it; e_fid = 1;
      m_flush = N; m_pend = 0; m_hold = 0;
    end
    cmp("model.load_next_pc", 32'(load_next_pc), 32'(e_lnp));
    cmp("model.bubble", 32'(bubble_from_decoder), 32'(e_bub));
    cmp("model.flush_if_id", 32'(flush_if_id), 32'(e_fif));
    cmp("model.flush_id_ex", 32'(flush_id_ex), 32'(e_fid));
    cmp("model.trap_ack", 32'(trap_ack), 32'(e_ack));
    if (e_lnp || !rst) cmp("model.next_pc", next_pc, e_npc);
  end

  initial begin
    repeat (3) begin
      applyStimulus(0, 0, 0, 1, 32'h104, 0, 0);
      checkOutput("reset", 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("release", 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 1, 32'h104, 0, 0);
    checkOutput("branch", 1, 0, 0, 1, 0, 32'h104);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    checkOutput("flush1_lu_ignored", 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("flush2", 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_done", 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("stall_hold", 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h80, 0, 0, 0, 1);
    checkOutput("pend_latch", 0, 1, 0, 0, 0, 0);
    repeat (2) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      checkOutput("pend_wait", 0, 1, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("pend_issue", 1, 0, 0, 1, 1, 32'h80);
    repeat (2) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("pend_flush", 0, 0, 1, 0, 0, 0);
    end

    applyStimulus(1, 1, 32'h200, 1, 32'h300, 0, 0);
    checkOutput("trap_wins", 1, 0, 0, 1, 1, 32'h200);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);

    repeat (2) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 0);
      checkOutput("load_use", 0, 1, 0, 1, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("load_use_end", 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 1, 32'h400, 0, 0);
    checkOutput("branch_before_reset", 1, 0, 0, 1, 0, 32'h400);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("midflush_reset", 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("post_reset", 0, 0, 0, 0, 0, 0);
    end

    applyStimulus(1, 0, 0, 1, 32'h107, 0, 0);
    checkOutput("unaligned", 1, 0, 0, 1, 0, 32'h104);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(63) != 0),
                    ($urandom_range(11) == 0), $urandom,
                    ($urandom_range(5) == 0), $urandom,
                    ($urandom_range(5) == 0), ($urandom_range(3) == 0));
    end
    repeat (4) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Pipeline sequencing controller for the instruction-fetch stage. It turns hazard and redirect events from decode, execute and memory into the fetch stage's `next_pc`, `load_next_pc` and `bubble_from_decoder` controls. It also squashes the wrong-path instructions already in flight through the fetch/i_cache pipeline. It sits between the fetch stage and the decode/execute/memory control logic, and is the only driver of those fetch inputs.

## Interface
- `FLUSH_CYCLES`, default 2: cycles of wrong-path fetch output to squash after a redirect (PC register plus registered i_cache read).
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous reset, active-low. The block is in reset while `rst`=0 at a rising edge.
- `trap_req` in 1: trap/exception request from execute, valid for one cycle.
- `trap_vector` in 32: trap handler address.
- `br_taken` in 1: taken branch or jump resolved in execute, valid for one cycle.
- `br_target` in 32: branch target.
- `load_use` in 1: load-use hazard detected in decode.
- `mem_stall` in 1: data memory busy; the whole front end must hold.
- `next_pc` out 32: redirect address to fetch.
- `load_next_pc` out 1: one-cycle redirect strobe.
- `bubble_from_decoder` out 1: fetch holds its PC.
- `flush_if_id` out 1: invalidate the instruction entering decode.
- `flush_id_ex` out 1: insert a bubble into execute.
- `trap_ack` out 1: one-cycle pulse when a trap redirect is issued.

## Operation
- States: RUN, HOLD, PEND and FLUSH. There is a `flush_cnt` counter of width clog2(FLUSH_CYCLES+1) and a 32-bit `pend_pc` register.
- Event priority: trap > branch > mem_stall > load_use. A trap and a branch in the same cycle: the trap wins and the branch is dropped.
- `next_pc` is always driven with bits [1:0] forced to 00. An unaligned target is silently truncated.

RUN:
- Redirect event with `mem_stall`=0:
  - Drive `load_next_pc`=1, `next_pc`=target and `flush_id_ex`=1 combinationally in the same cycle.
  - Pulse `trap_ack` if the event is a trap.
  - Load `flush_cnt`=FLUSH_CYCLES and go to FLUSH.
- Redirect event with `mem_stall`=1:
  - Latch the target into `pend_pc`, latch the trap flag, and go to PEND.
  - `bubble_from_decoder`=1.
  - No strobe, no ack.
- `mem_stall` alone: `bubble_from_decoder`=1, go to HOLD.
- `load_use` alone: `bubble_from_decoder`=1 and `flush_id_ex`=1 for that cycle. Stay in RUN.

HOLD:
- `bubble_from_decoder`=1.
- A redirect arriving in HOLD is handled exactly as in RUN, gated on the current `mem_stall`.
- Return to RUN in the cycle after `mem_stall`=0.

PEND:
- `bubble_from_decoder`=1 while `mem_stall`=1.
- A new trap overwrites `pend_pc`; a new branch is ignored.
- First cycle with `mem_stall`=0: issue the pending redirect as in RUN (strobe, ack if a trap was latched, `flush_id_ex`), then go to FLUSH.

FLUSH:
- `flush_if_id`=1 every cycle.
- `flush_cnt` decrements only when `mem_stall`=0, and frozen cycles keep `bubble_from_decoder`=1. Go to RUN when the count reaches 0.
- `load_use` and `br_taken` are ignored, because they come from wrong-path instructions.
- `trap_req` re-issues a redirect and reloads `flush_cnt`.

Reset:
- While reset is active, every output is 0, the state is RUN, and `flush_cnt` and `pend_pc` are 0.
- A reset in the middle of PEND or FLUSH discards the pending redirect; no `trap_ack` is produced.

## Timing
- Redirect latency: the event seen in cycle t (with no stall) gives `load_next_pc`=1 in cycle t, and fetch loads the PC at the edge ending t.
- `flush_if_id` is asserted in cycles t+1 … t+FLUSH_CYCLES, with no stall in between.
- `load_use` produces exactly one bubble cycle per asserted cycle, with no added latency.
- `load_next_pc` and `trap_ack` are never asserted for two consecutive cycles, except for back-to-back traps in FLUSH.
- `load_next_pc` is never asserted while `mem_stall`=1.
- First cycle after reset release: RUN, all outputs 0 unless inputs are active.

## Structure
- Shared package `fetch_pkg`: `fetch_ctrl_state_t` enum {RUN, HOLD, PEND, FLUSH} and the alignment mask constant `PC_ALIGN_MASK`=32'hFFFF_FFFC.
- No sub-module. One state register `always_ff`, one output `always_comb`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `br_taken`=1 → all outputs 0. After release, state is RUN and `flush_if_id`=0.
- Branch: `br_taken`=1, `br_target`=0x0000_0104 in cycle 10 → `load_next_pc`=1 and `next_pc`=0x104 in cycle 10; `flush_if_id`=1 in cycles 11–12; `load_use` pulsed in cycle 11 is ignored.
- Pending redirect: `mem_stall` high in cycles 5–8 and `trap_req` (vector 0x80) in cycle 6 → bubble in cycles 5–8; `load_next_pc`, `trap_ack` and `next_pc`=0x80 in cycle 9.
- Simultaneous trap and branch: trap 0x200 plus branch 0x300 in the same cycle → `next_pc`=0x200, `trap_ack`=1.
- Load-use: `load_use`=1 in cycles 3–4 → `bubble_from_decoder`=1 and `flush_id_ex`=1 in exactly cycles 3–4.
- Mid-flush reset: branch in cycle 10, `rst`=0 in cycle 11 → `flush_if_id`=0 from cycle 11; after release, no redirect is re-issued.
